// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the I/D-cache memory port arbiter.
//   arb_state_e            : arbiter FSM encoding (IDLE, GRANT_I, GRANT_D, RELEASE)
//   GNT_NONE/GNT_I/GNT_D   : one-hot grant values, bit 1 = D-cache, bit 0 = I-cache
//   ADDR_W_DEF/DATA_W_DEF  : default line address / line data widths
// Optional build macro used by the arbiter: MEM_ARB_RR_EN (round-robin tie break).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the memory port arbiter.
// Ports:
//   i_pend, d_pend : requester pending flags (read | write)
//   last_grant     : requester served last, 0 = I-cache, 1 = D-cache
//   grant_nxt      : one-hot winner, GNT_NONE when nobody is pending
// Build macro MEM_ARB_RR_EN: when defined, ties go to the requester not served
// last; when undefined, the D-cache always wins a tie and last_grant is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_pend,
  input  logic       d_pend,
  input  logic       last_grant,
  output logic [1:0] grant_nxt
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_nxt = GNT_NONE;
    if (i_pend && d_pend) begin
      grant_nxt = last_grant ? GNT_I : GNT_D;
    end else if (d_pend) begin
      grant_nxt = GNT_D;
    end else if (i_pend) begin
      grant_nxt = GNT_I;
    end
  end
`else
  // Loads/stores stall the whole pipe, so the D-cache is always preferred.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_nxt = GNT_NONE;
    if (d_pend) begin
      grant_nxt = GNT_D;
    end else if (i_pend) begin
      grant_nxt = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 128-bit line memory port between the I-cache
// and D-cache miss engines, one whole line transaction at a time.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_mem_* / d_mem_*               : requester side (read, write, addr, wdata in;
//                                     rdata, ready out)
//   mem_read/write/addr/wdata       : to memory, muxed from the granted requester
//   mem_rdata, mem_ready            : from memory; ready is a one-cycle done pulse
//   grant                           : one-hot owner, [1]=D, [0]=I, 00 = none
// Build macro MEM_ARB_RR_EN: round-robin tie break instead of fixed D priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] grant_nxt;
  logic       i_pend, d_pend;

  assign i_pend = i_mem_read | i_mem_write;
  assign d_pend = d_mem_read | d_mem_write;

  mem_arb_pick u_pick (
    .i_pend     (i_pend),
    .d_pend     (d_pend),
    .last_grant (last_grant_q),
    .grant_nxt  (grant_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_nxt != GNT_NONE) begin
          grant_d      = grant_nxt;
          last_grant_d = grant_nxt[1];
          state_d      = grant_nxt[1] ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        // Ownership lasts until memory reports completion, even if the
        // requester has already withdrawn.
        if (mem_ready) begin
          state_d = RELEASE;
          grant_d = GNT_NONE;
        end
      end
      RELEASE: begin
        // Dead cycle so the served cache can drop its request before the
        // next arbitration sees it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // A simultaneous read+write is illegal; the write takes the port.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    if (grant_q == GNT_I) begin
      i_mem_ready = mem_ready;
      if (i_pend) begin
        mem_write = i_mem_write;
        mem_read  = i_mem_read & ~i_mem_write;
        mem_addr  = i_mem_addr;
        mem_wdata = i_mem_wdata;
      end
    end else if (grant_q == GNT_D) begin
      d_mem_ready = mem_ready;
      if (d_pend) begin
        mem_write = d_mem_write;
        mem_read  = d_mem_read & ~d_mem_write;
        mem_addr  = d_mem_addr;
        mem_wdata = d_mem_wdata;
      end
    end
  end

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign grant       = grant_q;

`ifndef SYNTHESIS
  a_no_rw_i : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT_I) |-> !(i_mem_read && i_mem_write))
    else $warning("I-cache asserted read and write together; write forwarded");
  a_no_rw_d : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT_D) |-> !(d_mem_read && d_mem_write))
    else $warning("D-cache asserted read and write together; write forwarded");
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow-memory port between the instruction-cache and data-cache miss engines.
- Lets CHIP run on a single 128-bit line memory instead of separate mem_*_I / mem_*_D ports.
- Grants one whole transaction (one line read or one line write) at a time.
- Forwards the granted cache's request to memory and routes mem_ready back only to that cache.

Parameters:
- ADDR_W, 28, line address width (address bits [31:4]).
- DATA_W, 128, line data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_mem_read  in  1  I-cache line read request.
- i_mem_write  in  1  I-cache line write request (normally 0).
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_wdata  in  DATA_W  I-cache write line.
- i_mem_rdata  out  DATA_W  read line to I-cache.
- i_mem_ready  out  1  transaction-done pulse to I-cache.
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same meanings, for the D-cache.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_rdata  in  DATA_W  from memory.
- mem_ready  in  1  from memory, one-cycle pulse when done.
- grant  out  2  one-hot owner: [1]=D, [0]=I, 00=none.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset state:
  - state=IDLE, grant=00.
  - mem_read=0, mem_write=0.
  - mem_addr=0, mem_wdata=0.
  - i_mem_ready=0, d_mem_ready=0.
- A requester is pending when its read|write is 1.
- Requester protocol: hold read/write, addr and wdata stable until its ready pulse is seen.
- FSM states and transitions:
  - IDLE: if any requester is pending, pick a winner and register grant. Next state is GRANT_I or GRANT_D.
  - Arbitration latency: request seen at cycle t gives mem_read/mem_write asserted at cycle t+1.
  - GRANT_x: memory outputs are the registered-grant mux of requester x's inputs.
  - GRANT_x: memory outputs are 0 when requester x is not pending.
  - GRANT_x: x_mem_ready = mem_ready (combinational). The other requester's ready is 0.
  - GRANT_x: on mem_ready=1, go to RELEASE. grant stays set through that cycle.
  - RELEASE: one cycle, grant=00, all memory strobes 0. Then go to IDLE.
  - RELEASE exists so the just-served cache can drop its stale request before it is re-arbitrated.
- Read data: i_mem_rdata and d_mem_rdata both carry mem_rdata (broadcast). Only the ready pulse qualifies it.
- Read and write both asserted by the granted requester: illegal. The write is forwarded and the read is masked; the simulation-only assertion flags it.
- Granted requester deasserts before mem_ready: memory strobes drop to 0 and the FSM stays in GRANT_x until mem_ready. It returns to IDLE without re-grant only if mem_ready arrives.
- A new request from the non-granted cache is held off (its ready stays 0) until the next IDLE.
- Write-back then allocate from one cache is two transactions. The other cache may win in between.
- Reset asserted mid-transaction: immediate return to the reset state. The memory model is also reset, so no transaction is completed.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Without it: fixed priority, D wins over I when both are pending in IDLE (loads/stores block the whole pipe).
- With it: one-bit last_grant register, reset to I.
  - On a tie, the requester not served last wins.
  - A single pending requester always wins.
  - last_grant updates on entry to GRANT_x.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding IDLE/GRANT_I/GRANT_D/RELEASE.
  - Grant one-hot constants GNT_NONE/GNT_I/GNT_D.
  - ADDR_W/DATA_W defaults.
- One sub-module, mem_arb_pick: combinational winner select from (i_pend, d_pend, last_grant) producing one-hot grant_nxt.
- The RR/fixed variant lives entirely inside mem_arb_pick.

Test Plan:
- Single I read, addr 0x0000010:
  - grant=01 at t+1 with mem_read=1, mem_addr=0x0000010.
  - mem_ready after 4 cycles: i_mem_ready=1 for exactly that cycle, d_mem_ready=0.
  - Then one RELEASE cycle with grant=00, then IDLE.
- Simultaneous I read 0x10 and D write 0x20 (wdata 0xA5..A5), fixed priority:
  - D granted first: mem_write=1, mem_addr=0x20, mem_wdata=0xA5..A5.
  - I served only after D's RELEASE cycle.
  - i_mem_ready never pulses during the D transaction.
- Same stimulus with MEM_ARB_RR_EN, after a prior D transaction:
  - I wins the tie, then D.
  - Two back-to-back ties alternate I, D, I, D.
- D write-back 0x30 then read 0x40 while I keeps requesting 0x50 (RR on):
  - Order is D write, I read, D read.
  - Each transaction is separated by RELEASE.
- rst_n pulled low during GRANT_D before mem_ready:
  - All outputs go to reset values asynchronously.
  - After release, a fresh D request is re-granted with 1-cycle latency.
- Granted D asserts read and write together: write forwarded, mem_read=0, assertion fires.
